// File: rtl/output_arbiter_pkg.sv
// Shared NoC definitions: flit type codes, port codes, flit width and arbiter state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package output_arbiter_pkg;

    // Default flit width; the low two bits of every flit carry its type.
    localparam int NOC_FLIT_W = 8;

    localparam logic [1:0] FT_HEAD = 2'b11;
    localparam logic [1:0] FT_BODY = 2'b01;
    localparam logic [1:0] FT_TAIL = 2'b10;

    // Owner / round-robin pointer width; wide enough for the five router ports.
    localparam int OWNER_W = 3;

    // Requester index equals the port code.
    typedef enum logic [OWNER_W-1:0] {
        PORT_N = 3'd0,
        PORT_S = 3'd1,
        PORT_E = 3'd2,
        PORT_W = 3'd3,
        PORT_L = 3'd4
    } port_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/output_arbiter_if.sv
// Handshake bundle between the input VC buffers, one output arbiter and its output link.
// Latency: n/a (wires only).
// Backpressure: in_ready per requester from the arbiter; credit_in pulses from downstream.
// Ports: master = upstream/downstream side, slave = arbiter side.
interface output_arbiter_if
    import output_arbiter_pkg::*;
#(
    parameter int NUM_IN = 5,
    parameter int FLIT_W = NOC_FLIT_W
);
    logic [NUM_IN-1:0]        in_valid;
    logic [NUM_IN*FLIT_W-1:0] in_flit;
    logic [NUM_IN-1:0]        in_ready;
    logic                     credit_in;
    logic                     out_valid;
    logic [FLIT_W-1:0]        out_flit;
    logic [OWNER_W-1:0]       owner;
    logic                     locked;

    modport master (
        output in_valid, in_flit, credit_in,
        input  in_ready, out_valid, out_flit, owner, locked
    );

    modport slave (
        input  in_valid, in_flit, credit_in,
        output in_ready, out_valid, out_flit, owner, locked
    );
endinterface

// File: rtl/output_arbiter_rr_picker.sv
// Round-robin one-hot picker: first request scanning upward (with wrap) from i_ptr+1.
// Latency: combinational.
// Backpressure: none; o_grant is zero when no request is present.
// Ports: i_req request vector, i_ptr last-served index, o_grant one-hot winner.
module rr_picker #(
    parameter int NUM_IN = 5,
    parameter int PTR_W  = 3
) (
    input  logic [NUM_IN-1:0] i_req,
    input  logic [PTR_W-1:0]  i_ptr,
    output logic [NUM_IN-1:0] o_grant
);
    int   w_idx;
    logic w_found;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = 0;
        // Offsets 1..NUM_IN visit every requester once, the last-served one last.
        for (int k = 1; k <= NUM_IN; k++) begin
            w_idx = (int'(i_ptr) + k) % NUM_IN;
            for (int i = 0; i < NUM_IN; i++) begin
                if (!w_found && (i == w_idx) && i_req[i]) begin
                    o_grant[i] = 1'b1;
                    w_found    = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/output_arbiter.sv
// Output-port switch allocator: round-robin among HEAD flits, wormhole lock until TAIL, credit metered.
// Latency: 1 cycle from in_ready/transfer to out_valid/out_flit.
// Backpressure: in_ready is zero while credits==0, and only the lock owner is served while locked.
// Ports: clk, reset (async active-low), bus (slave modport of output_arbiter_if).
module output_arbiter
    import output_arbiter_pkg::*;
#(
    parameter int NUM_IN  = 5,
    parameter int FLIT_W  = NOC_FLIT_W,
    parameter int CREDITS = 4
) (
    input  logic            clk,
    input  logic            reset,
    output_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(CREDITS + 1);

    arb_state_e         r_state;
    arb_state_e         w_state_nxt;
    logic [OWNER_W-1:0] r_rr_ptr;
    logic [OWNER_W-1:0] r_owner;
    logic [CNT_W-1:0]   r_credits;
    logic               r_out_vld;
    logic [FLIT_W-1:0]  r_out_flit;

    logic [NUM_IN-1:0]  w_head;
    logic [NUM_IN-1:0]  w_grant;
    logic [NUM_IN-1:0]  w_ready;
    logic [OWNER_W-1:0] w_win_idx;
    logic               w_own_vld;
    logic [FLIT_W-1:0]  w_own_flit;
    logic [FLIT_W-1:0]  w_xfer_flit;
    logic               w_credit_ok;
    logic               w_xfer;
    logic               w_tail_xfer;

    // Only HEAD flits compete; stray BODY/TAIL at IDLE stay blocked.
    for (genvar i = 0; i < NUM_IN; i++) begin : g_head
        assign w_head[i] = bus.in_valid[i] && (bus.in_flit[i*FLIT_W +: 2] == FT_HEAD);
    end

    rr_picker #(
        .NUM_IN (NUM_IN),
        .PTR_W  (OWNER_W)
    ) u_rr_picker (
        .i_req   (w_head),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant)
    );

    assign w_credit_ok = (r_credits != '0);

    // Winner index and the owner's view of the request bus.
    always_comb begin
        w_win_idx  = '0;
        w_own_vld  = 1'b0;
        w_own_flit = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_grant[i]) begin
                w_win_idx = OWNER_W'(i);
            end
            if (OWNER_W'(i) == r_owner) begin
                w_own_vld  = bus.in_valid[i];
                w_own_flit = bus.in_flit[i*FLIT_W +: FLIT_W];
            end
        end
    end

    // Next state and grant. A HEAD from the owner while locked is just forwarded.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = '0;
        w_xfer      = 1'b0;
        w_tail_xfer = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((|w_grant) && w_credit_ok) begin
                    w_ready     = w_grant;
                    w_xfer      = 1'b1;
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                // An owner bubble (in_valid low) holds the lock.
                if (w_own_vld && w_credit_ok) begin
                    for (int i = 0; i < NUM_IN; i++) begin
                        if (OWNER_W'(i) == r_owner) begin
                            w_ready[i] = 1'b1;
                        end
                    end
                    w_xfer = 1'b1;
                    if (w_own_flit[1:0] == FT_TAIL) begin
                        w_tail_xfer = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Flit actually crossing: whichever requester holds the one-hot ready.
    always_comb begin
        w_xfer_flit = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_ready[i]) begin
                w_xfer_flit = bus.in_flit[i*FLIT_W +: FLIT_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_owner  <= '0;
            // Pointer at the last index gives requester 0 first priority.
            r_rr_ptr <= OWNER_W'(NUM_IN - 1);
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) && w_xfer) begin
                r_owner <= w_win_idx;
            end
            if (w_tail_xfer) begin
                r_rr_ptr <= r_owner;
            end
        end
    end

    // Credit counter: a return and a spend in the same cycle cancel out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_credits <= CNT_W'(CREDITS);
        end else begin
            case ({w_xfer, bus.credit_in})
                2'b10:   r_credits <= r_credits - CNT_W'(1);
                2'b01: begin
                    if (r_credits != CNT_W'(CREDITS)) begin
                        r_credits <= r_credits + CNT_W'(1);
                    end
                end
                default: r_credits <= r_credits;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_vld  <= 1'b0;
            r_out_flit <= '0;
        end else begin
            r_out_vld <= w_xfer;
            if (w_xfer) begin
                r_out_flit <= w_xfer_flit;
            end
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = r_out_vld;
    assign bus.out_flit  = r_out_flit;
    assign bus.owner     = r_owner;
    assign bus.locked    = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_output_arbiter.sv
// Bench for output_arbiter: directed per-cycle vectors with a scoreboard on the output link.
// Latency: n/a.
// Backpressure: n/a.
module tb_output_arbiter;
    import output_arbiter_pkg::*;

    logic clk;
    logic rst_n;

    output_arbiter_if #(.NUM_IN(5), .FLIT_W(8)) ifc ();

    output_arbiter #(
        .NUM_IN  (5),
        .FLIT_W  (8),
        .CREDITS (4)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] fl(input int p, input logic [7:0] val);
        logic [39:0] r;
        r = '0;
        r[p*8 +: 8] = val;
        return r;
    endfunction

    // One cycle: drive after the edge, check in_ready mid-cycle, queue the expected output flit.
    task automatic cyc(input logic [4:0] v, input logic [39:0] f, input logic c,
                       input logic [4:0] exp_rdy, input string name);
        @(posedge clk);
        #2;
        ifc.in_valid  = v;
        ifc.in_flit   = f;
        ifc.credit_in = c;
        #2;
        chk({name, " in_ready"}, 32'(ifc.in_ready), 32'(exp_rdy));
        for (int i = 0; i < 5; i++) begin
            if (exp_rdy[i]) exp_q.push_back(f[i*8 +: 8]);
        end
    endtask

    // Output monitor: every out_valid must match the oldest expected flit.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (ifc.out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL out_flit: unexpected flit %0h, expected none", ifc.out_flit);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_flit", 32'(ifc.out_flit), 32'(e));
                end
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        ifc.in_valid  = '0;
        ifc.in_flit   = '0;
        ifc.credit_in = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst out_valid", 32'(ifc.out_valid), 0);
        chk("rst out_flit",  32'(ifc.out_flit),  0);
        chk("rst owner",     32'(ifc.owner),     0);
        chk("rst locked",    32'(ifc.locked),    0);
        chk("rst in_ready",  32'(ifc.in_ready),  0);
        rst_n = 1'b1;

        // Single packet from L.
        cyc(5'b10000, fl(4, 8'h4B), 1'b1, 5'b10000, "L head");
        cyc(5'b10000, fl(4, 8'h49), 1'b1, 5'b10000, "L body");
        chk("L locked mid", 32'(ifc.locked), 1);
        cyc(5'b10000, fl(4, 8'h4A), 1'b1, 5'b10000, "L tail");
        cyc(5'b00000, '0,           1'b1, 5'b00000, "idle");
        chk("L locked after tail", 32'(ifc.locked), 0);
        chk("L owner", 32'(ifc.owner), 4);

        // Contention N vs E, 2-flit packets, no dead cycle.
        cyc(5'b00101, fl(0, 8'h03) | fl(2, 8'h23), 1'b1, 5'b00001, "ctn1 N");
        cyc(5'b00101, fl(0, 8'h02) | fl(2, 8'h23), 1'b1, 5'b00001, "ctn2 N");
        cyc(5'b00101, fl(0, 8'h03) | fl(2, 8'h23), 1'b1, 5'b00100, "ctn3 E");
        cyc(5'b00101, fl(0, 8'h03) | fl(2, 8'h22), 1'b1, 5'b00100, "ctn4 E");
        cyc(5'b00101, fl(0, 8'h03) | fl(2, 8'h23), 1'b1, 5'b00001, "ctn5 N");
        cyc(5'b00101, fl(0, 8'h02) | fl(2, 8'h23), 1'b1, 5'b00001, "ctn6 N");
        cyc(5'b00101, fl(0, 8'h03) | fl(2, 8'h23), 1'b1, 5'b00100, "ctn7 E");
        cyc(5'b00100, fl(2, 8'h22),                1'b1, 5'b00100, "ctn8 E");

        // W holds the lock across a 2-cycle bubble while N waits with a HEAD.
        cyc(5'b01001, fl(3, 8'h33) | fl(0, 8'h07), 1'b1, 5'b01000, "hold W head");
        cyc(5'b01001, fl(3, 8'h35) | fl(0, 8'h07), 1'b1, 5'b01000, "hold W body");
        cyc(5'b00001, fl(0, 8'h07),                1'b1, 5'b00000, "hold bubble1");
        cyc(5'b00001, fl(0, 8'h07),                1'b1, 5'b00000, "hold bubble2");
        chk("hold bubble out_valid", 32'(ifc.out_valid), 0);
        chk("hold bubble locked",    32'(ifc.locked),    1);
        chk("hold bubble owner",     32'(ifc.owner),     3);
        cyc(5'b01001, fl(3, 8'h39) | fl(0, 8'h07), 1'b1, 5'b01000, "hold W body2");
        cyc(5'b01001, fl(3, 8'h3A) | fl(0, 8'h07), 1'b1, 5'b01000, "hold W tail");
        cyc(5'b00001, fl(0, 8'h07),                1'b1, 5'b00001, "hold N head");
        cyc(5'b00001, fl(0, 8'h06),                1'b1, 5'b00001, "hold N tail");

        // Credit exhaustion: 6-flit packet from S, no returns.
        cyc(5'b00010, fl(1, 8'h13), 1'b0, 5'b00010, "cr head");
        cyc(5'b00010, fl(1, 8'h15), 1'b0, 5'b00010, "cr body1");
        cyc(5'b00010, fl(1, 8'h19), 1'b0, 5'b00010, "cr body2");
        cyc(5'b00010, fl(1, 8'h1D), 1'b0, 5'b00010, "cr body3");
        cyc(5'b00010, fl(1, 8'h21), 1'b0, 5'b00000, "cr empty");
        cyc(5'b00010, fl(1, 8'h21), 1'b1, 5'b00000, "cr return");
        cyc(5'b00010, fl(1, 8'h21), 1'b0, 5'b00010, "cr one flit");
        cyc(5'b00010, fl(1, 8'h21), 1'b0, 5'b00000, "cr empty2");
        cyc(5'b00010, fl(1, 8'h21), 1'b1, 5'b00000, "cr return2");
        // credits=1: spend and return together leave 1.
        cyc(5'b00010, fl(1, 8'h26), 1'b1, 5'b00010, "cr both tail");
        cyc(5'b00010, fl(1, 8'h13), 1'b0, 5'b00010, "cr still one");
        cyc(5'b00010, fl(1, 8'h26), 1'b0, 5'b00000, "cr then zero");
        // Five returns from zero: the fifth must saturate at 4.
        for (int i = 0; i < 5; i++) cyc(5'b00000, '0, 1'b1, 5'b00000, "cr refill");
        cyc(5'b00010, fl(1, 8'h26), 1'b0, 5'b00010, "sat S tail");
        cyc(5'b00001, fl(0, 8'h03), 1'b0, 5'b00001, "sat N head");
        cyc(5'b00001, fl(0, 8'h05), 1'b0, 5'b00001, "sat N body1");
        cyc(5'b00001, fl(0, 8'h05), 1'b0, 5'b00001, "sat N body2");
        cyc(5'b00001, fl(0, 8'h02), 1'b0, 5'b00000, "sat empty");
        cyc(5'b00001, fl(0, 8'h02), 1'b1, 5'b00000, "sat return");
        cyc(5'b00001, fl(0, 8'h02), 1'b1, 5'b00001, "sat N tail");

        // Reset in the middle of an E packet.
        cyc(5'b00100, fl(2, 8'h23), 1'b1, 5'b00100, "rst E head");
        cyc(5'b00100, fl(2, 8'h25), 1'b1, 5'b00100, "rst E body");
        @(posedge clk);
        #2;
        ifc.in_valid  = 5'b00100;
        ifc.in_flit   = fl(2, 8'h25);
        ifc.credit_in = 1'b0;
        rst_n         = 1'b0;
        #1;
        // The body accepted last cycle is lost with the reset.
        exp_q.delete();
        chk("mid rst out_valid", 32'(ifc.out_valid), 0);
        chk("mid rst out_flit",  32'(ifc.out_flit),  0);
        chk("mid rst owner",     32'(ifc.owner),     0);
        chk("mid rst locked",    32'(ifc.locked),    0);
        chk("mid rst in_ready",  32'(ifc.in_ready),  0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc(5'b00011, fl(0, 8'h03) | fl(1, 8'h13), 1'b0, 5'b00001, "post N head");
        cyc(5'b00011, fl(0, 8'h02) | fl(1, 8'h13), 1'b0, 5'b00001, "post N tail");
        cyc(5'b00010, fl(1, 8'h13),                1'b0, 5'b00010, "post S head");
        cyc(5'b00010, fl(1, 8'h12),                1'b0, 5'b00010, "post S tail");
        cyc(5'b00000, '0,                          1'b0, 5'b00000, "drain idle");

        repeat (3) @(posedge clk);
        #4;
        chk("scoreboard drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
